flex_latency_monitor: RTL

Synthesizable, parametrised flex-channel (valid/ready) protocol and latency monitor for the L2 cache tag bank and its neighbours. It tracks up to DEPTH outstanding requests per channel across N_CH independent request/response channel pairs. It flags overflow, underflow, valid-drop and timeout violations as sticky error bits, and records the worst observed latency per channel. It sits beside the tag bank in simulation and in FPGA bring-up builds, and drives only status outputs.

---
 rtl/flex_mon_pkg.sv | 16 +
 rtl/flex_mon_ts_fifo.sv | 70 +++++++
 rtl/flex_latency_monitor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/flex_mon_pkg.sv
// rtl/flex_mon_pkg.sv - shared types and error-index constants for the flex-channel latency monitor
package flex_mon_pkg;

   localparam int TS_W_DEF = 16;
   typedef logic [TS_W_DEF-1:0] ts_t;

   // Position of each sticky error within a channel's error vector
   localparam int N_ERR    = 4;
   localparam int ERR_OVF  = 0;
   localparam int ERR_UNF  = 1;
   localparam int ERR_DROP = 2;
   localparam int ERR_TO   = 3;

   typedef logic [N_ERR-1:0] err_vec_t;

endpackage

// File: rtl/flex_mon_ts_fifo.sv
// rtl/flex_mon_ts_fifo.sv - per-channel register FIFO of request timestamps
module flex_mon_ts_fifo
   import flex_mon_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int TS_W  = 16,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [TS_W-1:0]  i_data,
   output logic [TS_W-1:0]  o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [TS_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push_en;
   logic             w_pop_en;

   assign o_full   = (r_count == CNT_W'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_head   = r_mem[r_rd_ptr];
   assign o_count  = r_count;

   // A pop on an empty FIFO is ignored; a push while full only lands when a pop frees the head slot
   assign w_pop_en  = i_pop & ~o_empty;
   assign w_push_en = i_push & (~o_full | w_pop_en);

   // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_en) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push_en, w_pop_en})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Timestamp storage, cleared on reset so an idle head never carries unknown values
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push_en) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

endmodule

// File: rtl/flex_latency_monitor.sv
// rtl/flex_latency_monitor.sv - multi-channel valid/ready protocol checker and worst-case latency recorder
module flex_latency_monitor
   import flex_mon_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int DEPTH = 4,
   parameter  int TS_W  = 16,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clear,
   input  logic [TS_W-1:0]       i_lat_limit,
   input  logic [N_CH-1:0]       i_req_valid,
   input  logic [N_CH-1:0]       i_req_ready,
   input  logic [N_CH-1:0]       i_rsp_valid,
   input  logic [N_CH-1:0]       i_rsp_ready,
   output logic [N_CH-1:0]       o_err_overflow,
   output logic [N_CH-1:0]       o_err_underflow,
   output logic [N_CH-1:0]       o_err_drop,
   output logic [N_CH-1:0]       o_err_timeout,
   output logic                  o_err_any,
   output logic [N_CH*CNT_W-1:0] o_outstanding,
   output logic [N_CH*TS_W-1:0]  o_max_lat
);

   logic [TS_W-1:0]  r_now;
   logic [N_CH-1:0]  w_push;
   logic [N_CH-1:0]  w_pop;
   logic [N_CH-1:0]  r_req_hold;
   logic [N_CH-1:0]  r_rsp_hold;

   logic [TS_W-1:0]  w_head     [N_CH];
   logic [CNT_W-1:0] w_count    [N_CH];
   logic             w_full     [N_CH];
   logic             w_empty    [N_CH];
   logic [TS_W-1:0]  w_age      [N_CH];
   err_vec_t         w_err_new  [N_CH];
   err_vec_t         w_err_nxt  [N_CH];
   err_vec_t         r_err      [N_CH];
   logic [TS_W-1:0]  w_lat_base [N_CH];
   logic [TS_W-1:0]  w_max_nxt  [N_CH];
   logic [TS_W-1:0]  r_max_lat  [N_CH];
   logic             w_err_any_nxt;
   logic             r_err_any;

   assign w_push = i_req_valid & i_req_ready;
   assign w_pop  = i_rsp_valid & i_rsp_ready;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      flex_mon_ts_fifo #(
         .DEPTH (DEPTH),
         .TS_W  (TS_W)
      ) u_fifo (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_push  (w_push[g]),
         .i_pop   (w_pop[g]),
         .i_data  (r_now),
         .o_head  (w_head[g]),
         .o_count (w_count[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g])
      );

      assign o_err_overflow[g]               = r_err[g][ERR_OVF];
      assign o_err_underflow[g]              = r_err[g][ERR_UNF];
      assign o_err_drop[g]                   = r_err[g][ERR_DROP];
      assign o_err_timeout[g]                = r_err[g][ERR_TO];
      assign o_outstanding[g*CNT_W +: CNT_W] = w_count[g];
      assign o_max_lat[g*TS_W +: TS_W]       = r_max_lat[g];
   end

   assign o_err_any = r_err_any;

   // Per-channel violation detection and next-state of sticky errors and worst latency
   always_comb begin
      w_err_any_nxt = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         // Modular subtraction keeps the age correct across timestamp wrap
         w_age[i] = r_now - w_head[i];

         w_err_new[i]           = '0;
         w_err_new[i][ERR_OVF]  = w_push[i] & w_full[i] & ~w_pop[i];
         w_err_new[i][ERR_UNF]  = w_pop[i] & w_empty[i];
         w_err_new[i][ERR_DROP] = (r_req_hold[i] & ~i_req_valid[i]) |
                                  (r_rsp_hold[i] & ~i_rsp_valid[i]);
         w_err_new[i][ERR_TO]   = ~w_empty[i] & (i_lat_limit != '0) &
                                  (w_age[i] > i_lat_limit);

         // Clear drops old state but an error seen in the same cycle still lands
         w_err_nxt[i] = (i_clear ? err_vec_t'(0) : r_err[i]) | w_err_new[i];

         w_lat_base[i] = i_clear ? '0 : r_max_lat[i];
         w_max_nxt[i]  = w_lat_base[i];
         if (w_pop[i] & ~w_empty[i] & (w_age[i] > w_lat_base[i])) begin
            w_max_nxt[i] = w_age[i];
         end

         w_err_any_nxt = w_err_any_nxt | (|w_err_nxt[i]);
      end
   end

   // Timestamp counter, valid-without-ready history and registered status
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_now      <= '0;
         r_req_hold <= '0;
         r_rsp_hold <= '0;
         r_err_any  <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            r_err[i]     <= '0;
            r_max_lat[i] <= '0;
         end
      end else begin
         r_now      <= r_now + TS_W'(1);
         r_req_hold <= i_req_valid & ~i_req_ready;
         r_rsp_hold <= i_rsp_valid & ~i_rsp_ready;
         r_err_any  <= w_err_any_nxt;
         for (int i = 0; i < N_CH; i++) begin
            r_err[i]     <= w_err_nxt[i];
            r_max_lat[i] <= w_max_nxt[i];
         end
      end
   end

endmodule
